// File: rtl/up_core_pkg.sv
// up_core_pkg: opcodes, FSM states and width helpers shared by the up_core_param slice
package up_core_pkg;
  localparam int OPC_W = 5;
  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 5'h00, OP_LDI, OP_LDR, OP_STR, OP_LDM, OP_STM, OP_ADDI, OP_ADD, OP_ADC, OP_SUB,
    OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_CALL,
    OP_RET, OP_HALT
  } opcode_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;
  function automatic int ins_w(input int data_w);
    return OPC_W + data_w;
  endfunction
endpackage

// File: rtl/up_return_stack.sv
// up_return_stack: LIFO of return addresses; a push when full or a pop when empty is ignored
module up_return_stack #(
  parameter int STACK_DEPTH = 4,
  parameter int PC_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  logic [SPW-1:0] sp_q;
  logic [PC_W-1:0] mem_q [2**SPW];
  assign full = sp_q == SPW'(STACK_DEPTH);
  assign empty = sp_q == '0;
  assign dout = mem_q[sp_q - SPW'(1)];
  always_ff @(posedge clk or posedge rst)
    if (rst) sp_q <= '0;
    else if (push && !full) sp_q <= sp_q + SPW'(1);
    else if (pop && !empty) sp_q <= sp_q - SPW'(1);
  always_ff @(posedge clk)
    if (push && !full) mem_q[sp_q] <= din;
endmodule

// File: rtl/up_core_param.sv
// up_core_param: parametrised accumulator core with ready/valid fetch, sync data memory,
// Z/C flags, hardware call/return stack and a HALT state left only through Reset
module up_core_param import up_core_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int PC_W = 6,
  parameter int REG_AW = 4,
  parameter int STACK_DEPTH = 4,
  localparam int INS_W = ins_w(DATA_W)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              run,
  output logic              pm_req,
  output logic [PC_W-1:0]   pm_addr,
  input  logic              pm_valid,
  input  logic [INS_W-1:0]  pm_ins,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic [DATA_W-1:0] inR3,
  output logic              halted,
  output logic              stack_err,
  output logic [PC_W-1:0]   PC_Addr_o,
  output logic [DATA_W-1:0] Accu_out_o
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, tgt, st_dout;
  logic [DATA_W-1:0] acc_q, acc_d, x, r;
  logic [DATA_W:0] alu;
  logic [INS_W-1:0] ir_q, ir_d;
  logic [OPC_W-1:0] op;
  logic [REG_AW-1:0] idx;
  logic [DATA_W-1:0] regs_q [2**REG_AW];
  logic z_q, z_d, c_q, c_d, err_q, err_d, wa, reg_we, push, pop, st_full, st_empty;
  logic pm_req_q, dm_we_q, halted_q;
  assign op = ir_q[INS_W-1:DATA_W];
  assign x = ir_q[DATA_W-1:0];
  assign idx = x[REG_AW-1:0];
  assign tgt = x[PC_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);
  assign r = idx == REG_AW'(3) ? inR3 : regs_q[idx];
  up_return_stack #(.STACK_DEPTH(STACK_DEPTH), .PC_W(PC_W)) u_stack (
    .clk(clk), .rst(Reset), .push(push), .pop(pop), .din(pc_inc),
    .dout(st_dout), .full(st_full), .empty(st_empty)
  );
  // alu carries {C, A}; ops that leave C alone feed c_q straight through
  always_comb begin
    alu = {c_q, acc_q};
    wa = 1'b1;
    case (op)
      OP_LDI:  alu = {c_q, x};
      OP_LDR:  alu = {c_q, r};
      OP_ADDI: alu = {1'b0, acc_q} + {1'b0, x};
      OP_ADD:  alu = {1'b0, acc_q} + {1'b0, r};
      OP_ADC:  alu = {1'b0, acc_q} + {1'b0, r} + (DATA_W+1)'(c_q);
      OP_SUB:  alu = {acc_q < r, acc_q - r};
      OP_AND:  alu = {c_q, acc_q & r};
      OP_OR:   alu = {c_q, acc_q | r};
      OP_XOR:  alu = {c_q, acc_q ^ r};
      OP_NOT:  alu = {c_q, ~acc_q};
      OP_SHL:  alu = {acc_q, 1'b0};
      OP_SHR:  alu = {acc_q[0], 1'b0, acc_q[DATA_W-1:1]};
      default: wa = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    acc_d = acc_q;
    z_d = z_q;
    c_d = c_q;
    ir_d = ir_q;
    err_d = err_q;
    reg_we = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    case (state_q)
      S_IDLE:  state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: if (pm_valid) begin ir_d = pm_ins; state_d = S_EXEC; end
      S_EXEC: begin
        state_d = run ? S_FETCH : S_IDLE;
        pc_d = pc_inc;
        if (wa) begin acc_d = alu[DATA_W-1:0]; c_d = alu[DATA_W]; z_d = alu[DATA_W-1:0] == '0; end
        case (op)
          OP_STR:  reg_we = idx != REG_AW'(3);
          OP_LDM:  state_d = S_MEM;
          OP_JMP:  pc_d = tgt;
          OP_JZ:   pc_d = z_q ? tgt : pc_inc;
          OP_JNZ:  pc_d = z_q ? pc_inc : tgt;
          OP_JC:   pc_d = c_q ? tgt : pc_inc;
          OP_CALL: begin push = !st_full; pc_d = st_full ? pc_q : tgt; end
          OP_RET:  begin pop = !st_empty; pc_d = st_empty ? pc_q : st_dout; end
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
        if ((op == OP_CALL && st_full) || (op == OP_RET && st_empty)) begin
          err_d = 1'b1;
          state_d = S_HALT;
        end
      end
      S_MEM: begin
        acc_d = dm_rdata;
        z_d = dm_rdata == '0;
        state_d = run ? S_FETCH : S_IDLE;
      end
      default: ;
    endcase
  end
  // strobes are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      acc_q <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      ir_q <= '0;
      err_q <= 1'b0;
      pm_req_q <= 1'b0;
      dm_we_q <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < 2**REG_AW; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      acc_q <= acc_d;
      z_q <= z_d;
      c_q <= c_d;
      ir_q <= ir_d;
      err_q <= err_d;
      if (reg_we) regs_q[idx] <= acc_q;
      pm_req_q <= state_d == S_FETCH;
      dm_we_q <= state_d == S_EXEC && ir_d[INS_W-1:DATA_W] == OP_STM;
      halted_q <= state_d == S_HALT;
    end
  end
  assign pm_req = pm_req_q;
  assign pm_addr = pc_q;
  assign dm_we = dm_we_q;
  assign dm_addr = x;
  assign dm_wdata = acc_q;
  assign halted = halted_q;
  assign stack_err = err_q;
  assign PC_Addr_o = pc_q;
  assign Accu_out_o = acc_q;
endmodule

// File: tb/tb_up_core_param.sv
// tb_up_core_param: directed vector table plus hand sequences for fetch stalls, memory and stack
module tb_up_core_param;
  import up_core_pkg::*;
  localparam int DW = 8;
  localparam int PW = 6;
  localparam int IW = 13;
  typedef struct {
    logic [4:0] op;
    logic [7:0] x;
    logic [7:0] r3;
    logic [7:0] acc;
    logic z;
    logic c;
  } vec_t;
  logic clk = 1'b0, Reset = 1'b1, run = 1'b0, pm_valid = 1'b0;
  logic [IW-1:0] pm_ins = '0;
  logic [DW-1:0] dm_rdata, inR3 = '0;
  logic pm_req, dm_we, halted, stack_err;
  logic [PW-1:0] pm_addr, PC_Addr_o;
  logic [DW-1:0] dm_addr, dm_wdata, Accu_out_o;
  logic [DW-1:0] dmem [256];
  logic [PW-1:0] mpc;
  logic [7:0] t [4] = '{8'h10, 8'h20, 8'h30, 8'h38};
  vec_t v[$];
  int tests = 0, fails = 0, we_cnt = 0;
  always #5 clk = ~clk;
  up_core_param dut (
    .clk(clk), .Reset(Reset), .run(run), .pm_req(pm_req), .pm_addr(pm_addr),
    .pm_valid(pm_valid), .pm_ins(pm_ins), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .inR3(inR3), .halted(halted),
    .stack_err(stack_err), .PC_Addr_o(PC_Addr_o), .Accu_out_o(Accu_out_o)
  );
  always @(posedge clk) begin
    if (dm_we) begin
      dmem[dm_addr] <= dm_wdata;
      we_cnt <= we_cnt + 1;
    end
    dm_rdata <= dmem[dm_addr];
  end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [4:0] op, input logic [7:0] x);
    int n = 0;
    while (!pm_req && n < 20) begin @(negedge clk); n++; end
    if (!pm_req) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout: pm_req=0 expected 1");
    end
    pm_ins = {op, x};
    pm_valid = 1'b1;
    @(negedge clk);
    pm_valid = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v.push_back('{5'h01, 8'hF0, 8'h00, 8'hF0, 1'b0, 1'b0});
    v.push_back('{5'h06, 8'h20, 8'h00, 8'h10, 1'b0, 1'b1});
    v.push_back('{5'h06, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b1});
    v.push_back('{5'h09, 8'h03, 8'h01, 8'hFF, 1'b0, 1'b1});
    v.push_back('{5'h03, 8'h05, 8'h00, 8'hFF, 1'b0, 1'b1});
    v.push_back('{5'h01, 8'h0F, 8'h00, 8'h0F, 1'b0, 1'b1});
    v.push_back('{5'h07, 8'h05, 8'h00, 8'h0E, 1'b0, 1'b1});
    v.push_back('{5'h08, 8'h05, 8'h00, 8'h0E, 1'b0, 1'b1});
    v.push_back('{5'h0A, 8'h03, 8'h0A, 8'h0A, 1'b0, 1'b1});
    v.push_back('{5'h0B, 8'h03, 8'h50, 8'h5A, 1'b0, 1'b1});
    v.push_back('{5'h0C, 8'h05, 8'h00, 8'hA5, 1'b0, 1'b1});
    v.push_back('{5'h0D, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b1});
    v.push_back('{5'h0E, 8'h00, 8'h00, 8'hB4, 1'b0, 1'b0});
    v.push_back('{5'h0E, 8'h00, 8'h00, 8'h68, 1'b0, 1'b1});
    v.push_back('{5'h0F, 8'h00, 8'h00, 8'h34, 1'b0, 1'b0});
    v.push_back('{5'h03, 8'h02, 8'h00, 8'h34, 1'b0, 1'b0});
    v.push_back('{5'h02, 8'h05, 8'h00, 8'hFF, 1'b0, 1'b0});
    v.push_back('{5'h09, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0});
    v.push_back('{5'h0C, 8'h03, 8'h00, 8'h00, 1'b1, 1'b0});
    v.push_back('{5'h0D, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0});
    v.push_back('{5'h0F, 8'h00, 8'h00, 8'h7F, 1'b0, 1'b1});
    v.push_back('{5'h17, 8'h00, 8'h00, 8'h7F, 1'b0, 1'b1});
    v.push_back('{5'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1});
    v.push_back('{5'h02, 8'h02, 8'h00, 8'h34, 1'b0, 1'b1});
    v.push_back('{5'h03, 8'h03, 8'h00, 8'h34, 1'b0, 1'b1});
    v.push_back('{5'h02, 8'h03, 8'hC3, 8'hC3, 1'b0, 1'b1});
    Reset = 1'b1;
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pm_req", pm_req, 0);
    chk("rst_pc", PC_Addr_o, 0);
    chk("rst_acc", Accu_out_o, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stack_err", stack_err, 0);
    chk("rst_dm_we", dm_we, 0);
    Reset = 1'b0;
    @(negedge clk);
    chk("first_req", pm_req, 1);
    chk("first_addr", pm_addr, 0);
    mpc = '0;
    foreach (v[i]) begin
      inR3 = v[i].r3;
      issue(v[i].op, v[i].x);
      mpc = mpc + 6'd1;
      chk($sformatf("acc[%0d]", i), Accu_out_o, v[i].acc);
      issue(OP_JC, 8'h20);
      mpc = v[i].c ? 6'h20 : mpc + 6'd1;
      chk($sformatf("c_probe[%0d]", i), PC_Addr_o, mpc);
      issue(OP_JZ, 8'h30);
      mpc = v[i].z ? 6'h30 : mpc + 6'd1;
      chk($sformatf("z_probe[%0d]", i), PC_Addr_o, mpc);
    end
    chk("pre_reset_req", pm_req, 1);
    Reset = 1'b1;
    #1;
    chk("midfetch_req", pm_req, 0);
    chk("midfetch_pc", PC_Addr_o, 0);
    chk("midfetch_acc", Accu_out_o, 0);
    @(negedge clk);
    Reset = 1'b0;
    mpc = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_req[%0d]", i), pm_req, 1);
      chk($sformatf("stall_addr[%0d]", i), pm_addr, 0);
      chk($sformatf("stall_acc[%0d]", i), Accu_out_o, 0);
      @(negedge clk);
    end
    pm_ins = {OP_LDI, 8'h55};
    pm_valid = 1'b1;
    @(negedge clk);
    chk("stall_exec_req", pm_req, 0);
    pm_valid = 1'b0;
    @(negedge clk);
    chk("stall_ldi_acc", Accu_out_o, 8'h55);
    chk("stall_ldi_pc", PC_Addr_o, 1);
    mpc = 6'd1;
    issue(OP_LDI, 8'hAB);
    mpc = mpc + 6'd1;
    pm_ins = {OP_STM, 8'h05};
    pm_valid = 1'b1;
    @(negedge clk);
    chk("stm_we", dm_we, 1);
    chk("stm_addr", dm_addr, 8'h05);
    chk("stm_wdata", dm_wdata, 8'hAB);
    pm_valid = 1'b0;
    @(negedge clk);
    chk("stm_we_drop", dm_we, 0);
    mpc = mpc + 6'd1;
    issue(OP_LDI, 8'h00);
    mpc = mpc + 6'd1;
    issue(OP_LDM, 8'h05);
    mpc = mpc + 6'd1;
    chk("ldm_mem_acc", Accu_out_o, 8'h00);
    chk("ldm_mem_req", pm_req, 0);
    @(negedge clk);
    chk("ldm_acc", Accu_out_o, 8'hAB);
    chk("we_pulses", we_cnt, 1);
    issue(OP_JZ, 8'h30);
    mpc = mpc + 6'd1;
    chk("ldm_z_probe", PC_Addr_o, mpc);
    issue(OP_JMP, 8'h3F);
    chk("jmp_pc", PC_Addr_o, 6'h3F);
    issue(OP_NOP, 8'h00);
    chk("pc_wrap", pm_addr, 0);
    issue(OP_RET, 8'h00);
    chk("ret_empty_err", stack_err, 1);
    chk("ret_empty_halt", halted, 1);
    chk("ret_empty_pc", PC_Addr_o, 0);
    Reset = 1'b1;
    @(negedge clk);
    chk("rst_clears_err", stack_err, 0);
    chk("rst_clears_halt", halted, 0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(OP_CALL, t[i]);
      chk($sformatf("call_pc[%0d]", i), PC_Addr_o, t[i][5:0]);
    end
    for (int i = 3; i >= 0; i--) begin
      issue(OP_RET, 8'h00);
      chk($sformatf("ret_pc[%0d]", i), PC_Addr_o, i == 0 ? 6'h01 : t[i-1][5:0] + 6'd1);
    end
    for (int i = 0; i < 4; i++) issue(OP_CALL, t[i]);
    chk("refill_pc", PC_Addr_o, 6'h38);
    issue(OP_CALL, 8'h05);
    chk("overflow_err", stack_err, 1);
    chk("overflow_halt", halted, 1);
    chk("overflow_pc", PC_Addr_o, 6'h38);
    repeat (3) @(negedge clk);
    chk("halt_req", pm_req, 0);
    chk("halt_pc", PC_Addr_o, 6'h38);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/up_core_param.md
Name: up_core_param

Overview:
- Next-generation accumulator micro-core: a parametrised successor of the current fixed 8-bit processor top.
- Adds configurable data, PC and register-file widths.
- Adds a ready/valid program-memory fetch interface, an external synchronous data memory, Z/C flags with conditional branches, a hardware CALL/RET stack and a HALT state.
- Sits as the CPU block between an external program ROM and data RAM; debug outputs expose PC and Accu.

Parameters:
- DATA_W, 8, datapath width; operand field width; instruction width INS_W = 5 + DATA_W.
- PC_W, 6, program counter width (PC_W <= DATA_W).
- REG_AW, 4, register-file address width; 2**REG_AW registers (REG_AW <= DATA_W).
- STACK_DEPTH, 4, return-stack entries (>= 1).

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- run  in  1  when 0, the core parks in IDLE at the next instruction boundary.
- pm_req  out  1  fetch request.
- pm_addr  out  PC_W  fetch address (= PC).
- pm_valid  in  1  instruction valid; sampled only while pm_req=1.
- pm_ins  in  INS_W  instruction: [INS_W-1:DATA_W] opcode, [DATA_W-1:0] operand.
- dm_we  out  1  data-memory write strobe.
- dm_addr  out  DATA_W  data-memory address (= operand).
- dm_wdata  out  DATA_W  write data (= Accu).
- dm_rdata  in  DATA_W  read data, valid 1 cycle after dm_addr.
- inR3  in  DATA_W  external value returned by reads of register 3.
- halted  out  1  core in HALT.
- stack_err  out  1  sticky stack overflow/underflow.
- PC_Addr_o  out  PC_W  debug PC.
- Accu_out_o  out  DATA_W  debug accumulator.

Behaviour:
- Reset values: PC 0, Accu 0, Z 0, C 0, all registers 0, stack empty, state IDLE, halted 0, stack_err 0, pm_req 0, dm_we 0.
- States: IDLE, FETCH, EXEC, MEM, HALT.
  - IDLE: goes to FETCH when run=1.
  - FETCH: pm_req=1, pm_addr=PC. When pm_valid=1, latch pm_ins into IR and go to EXEC. Otherwise hold, with pm_addr stable.
  - EXEC: executes in 1 cycle and updates PC. LDM goes to MEM; HALT or a stack error goes to HALT; otherwise FETCH if run=1, else IDLE.
  - MEM: Accu <= dm_rdata, Z updated; then FETCH or IDLE per run.
  - HALT: exits only via Reset.
- Latency: 2 cycles per instruction with zero-wait fetch; LDM takes 3.
- Opcodes (x = operand; reg index = x[REG_AW-1:0]; target = x[PC_W-1:0]):
  - 00 NOP; 01 LDI A=x; 02 LDR A=R; 03 STR R=A; 04 LDM; 05 STM (dm_we=1 in EXEC).
  - 06 ADDI A+x; 07 ADD A+R; 08 ADC A+R+C; 09 SUB A-R.
  - 0A AND; 0B OR; 0C XOR (each with R).
  - 0D NOT A; 0E SHL (C=A[MSB]); 0F SHR (C=A[0]).
  - 10 JMP; 11 JZ; 12 JNZ; 13 JC; 14 CALL; 15 RET; 16 HALT.
  - 17-1F execute as NOP.
- Arithmetic: all values unsigned, DATA_W wide.
  - ADD/ADC: C = carry-out.
  - SUB: C = borrow (A < R); result is modulo 2**DATA_W.
  - Logic ops: C unchanged.
  - Z = (new A == 0) for every opcode that writes A.
- Register 3: reads return inR3; STR to register 3 is discarded.
- PC: next = PC+1 mod 2**PC_W (PC 2**PC_W-1 wraps to 0). A taken branch loads the target; an untaken branch increments.
- CALL: push PC+1 (wrapped) and jump. RET: pop into PC.
  - CALL when the stack is full, or RET when it is empty: no push/pop, PC holds at the faulting instruction, stack_err=1, go to HALT.
- dm_we is asserted exactly one cycle per STM; no other state drives it.
- pm_valid outside FETCH is ignored.
- Reset asserted in any state, including mid-fetch or in MEM, returns every item to its reset value immediately.

Decomposition:
- Package up_core_pkg holds:
  - opcode enum (5-bit);
  - state enum;
  - OPC_W=5 constant;
  - helper function for INS_W.
- Sub-module up_return_stack (parameters STACK_DEPTH, PC_W):
  - inputs push, pop, din;
  - outputs dout, full, empty;
  - asynchronous active-high reset.
- ALU stays inline or reuses the existing ALU widened to DATA_W.

Test Plan:
- Reset mid-FETCH with pm_req=1 -> pm_req 0, PC 0, Accu 0. Release with run=1 -> pm_req=1, pm_addr=0 on the first cycle after IDLE.
- LDI F0; ADDI 20 -> A=10, C=1, Z=0. ADDI F0 -> A=00, C=1, Z=1. SUB R3 with inR3=01 -> A=FF, C=1, Z=0.
- Hold pm_valid low for 3 cycles in FETCH -> pm_req held at 1, pm_addr constant, A/PC unchanged. Valid on the 4th cycle -> EXEC next cycle.
- Four nested CALLs then four RETs -> each RET returns to its CALL address + 1. A fifth nested CALL -> stack_err=1, halted=1, PC stays at that CALL.
- A=AB; STM 05 -> dm_we=1 for exactly one cycle with dm_addr 05, dm_wdata AB. Then LDI 00; LDM 05 (dm_rdata=AB) -> A=AB after 3 cycles, Z=0.
- JMP 3F; NOP at 3F -> next pm_addr=00. RET with empty stack -> stack_err=1, halted=1.
